bin_mask_framer_2048mmax: RTL and testbench

//  Sits directly downstream of the exponent shifter in the M/2 channelizer. Drops FFT bins whose

---
 rtl/bin_mask_framer_2048mmax_if.sv | 12 +
 rtl/bin_mask_framer_2048mmax.sv | 171 +++++++++++++++++
 tb/tb_bin_mask_framer_2048mmax.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bin_mask_framer_2048mmax_if.sv
// AXI-Stream style sample bus used on both sides of the bin mask framer.
// Carries {I,Q} data, the exponent/bin/eob tuser word and the frame tlast.
interface bin_mask_framer_2048mmax_if;
    logic        tvalid;
    logic [31:0] tdata;
    logic [23:0] tuser;
    logic        tlast;
    logic        tready;

    modport master (output tvalid, tdata, tuser, tlast, input tready);
    modport slave  (input tvalid, tdata, tuser, tlast, output tready);
endinterface

// File: rtl/bin_mask_framer_2048mmax.sv
// Drops FFT bins whose mask bit is clear (or bin >= fft_size) and re-frames so tlast
// marks the last enabled bin of each frame; output buffered in a FIFO with almost-full flow control.
module bin_mask_framer_2048mmax #(
    parameter logic INIT_ENABLE = 1'b1,
    parameter int   FIFO_ADDR_W = 6,
    parameter int   AF_THRESH   = 16
) (
    input  logic                               clk,
    input  logic                               sync_reset,
    bin_mask_framer_2048mmax_if.slave          s_axis,
    bin_mask_framer_2048mmax_if.master         m_axis,
    input  logic [11:0]                        fft_size,
    input  logic                               mask_wr_en,
    input  logic [10:0]                        mask_wr_addr,
    input  logic                               mask_wr_data,
    output logic [15:0]                        drop_cnt,
    output logic                               eob_tag
);
    localparam int DEPTH = 1 << FIFO_ADDR_W;

    typedef struct packed {
        logic [23:0] user;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic take;
    assign take = s_axis.tvalid & s_axis.tready;

    // Mask bits are stored relative to INIT_ENABLE so the all-zero power-up RAM content reads as INIT_ENABLE.
    logic mask_mem [2048];
    logic s1_mask_q;

    // NOTE: the mask RAM and its read register carry no reset so they map onto block RAM;
    // validity is tracked by the separately reset s1_valid_q.
    always_ff @(posedge clk) begin
        if (mask_wr_en) mask_mem[mask_wr_addr] <= mask_wr_data ^ INIT_ENABLE;
        if (take)       s1_mask_q <= mask_mem[s_axis.tuser[10:0]] ^ INIT_ENABLE;
    end

    logic  s1_valid_q;
    logic  s1_inrange_q;
    beat_t s1_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            s1_valid_q   <= 1'b0;
            s1_inrange_q <= 1'b0;
            s1_q         <= '0;
        end else begin
            s1_valid_q <= take;
            if (take) begin
                s1_q         <= '{user: s_axis.tuser, data: s_axis.tdata, last: s_axis.tlast};
                s1_inrange_q <= ({1'b0, s_axis.tuser[10:0]} < fft_size);
            end
        end
    end

    logic        hold_valid_q, hold_valid_d;
    logic        flush_pend_q, flush_pend_d;
    beat_t       hold_q, hold_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        s1_en, s1_dis, push;
    beat_t       push_beat;

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        s1_en        = s1_valid_q & s1_mask_q & s1_inrange_q;
        s1_dis       = s1_valid_q & ~s1_en;
        push         = 1'b0;
        push_beat    = hold_q;
        hold_valid_d = hold_valid_q;
        flush_pend_d = flush_pend_q;
        hold_d       = hold_q;
        drop_cnt_d   = drop_cnt_q;

        // The held bin is only released once we know whether it ends its frame.
        if (flush_pend_q) begin
            push           = 1'b1;
            push_beat.last = 1'b1;
            hold_valid_d   = 1'b0;
            flush_pend_d   = 1'b0;
        end else if (s1_en && hold_valid_q) begin
            push           = 1'b1;
            push_beat.last = 1'b0;
        end else if (s1_dis && s1_q.last && hold_valid_q) begin
            push           = 1'b1;
            push_beat.last = 1'b1;
            hold_valid_d   = 1'b0;
        end

        if (s1_en) begin
            hold_d       = s1_q;
            hold_valid_d = 1'b1;
            flush_pend_d = s1_q.last;
        end
        if (s1_dis) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            hold_valid_q <= 1'b0;
            flush_pend_q <= 1'b0;
            hold_q       <= '0;
            drop_cnt_q   <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            flush_pend_q <= flush_pend_d;
            hold_q       <= hold_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    // Output FIFO: storage RAM plus a registered head that holds its data when empty.
    beat_t                  fifo_mem [DEPTH];
    logic [FIFO_ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_ADDR_W:0]   count_q;
    logic                   out_valid_q;
    beat_t                  out_q;
    logic                   mem_empty, out_load, mem_rd, mem_wr;

    always_comb begin
        mem_empty = (count_q == '0);
        out_load  = ~out_valid_q | m_axis.tready;
        mem_rd    = out_load & ~mem_empty;
        mem_wr    = push & ~(out_load & mem_empty);
    end

    always_ff @(posedge clk) begin
        if (mem_wr) fifo_mem[wr_ptr_q] <= push_beat;
    end

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            if (mem_wr) wr_ptr_q <= wr_ptr_q + FIFO_ADDR_W'(1);
            if (mem_rd) rd_ptr_q <= rd_ptr_q + FIFO_ADDR_W'(1);
            case ({mem_wr, mem_rd})
                2'b10:   count_q <= count_q + (FIFO_ADDR_W + 1)'(1);
                2'b01:   count_q <= count_q - (FIFO_ADDR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (out_load) begin
                if (!mem_empty) begin
                    out_q       <= fifo_mem[rd_ptr_q];
                    out_valid_q <= 1'b1;
                end else if (push) begin
                    out_q       <= push_beat;
                    out_valid_q <= 1'b1;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    // AF_THRESH leaves room for the taken sample, S1 and the hold register still in flight.
    assign s_axis.tready = (DEPTH - int'(count_q)) >= AF_THRESH;
    assign m_axis.tvalid = out_valid_q;
    assign m_axis.tdata  = out_q.data;
    assign m_axis.tuser  = out_q.user;
    assign m_axis.tlast  = out_q.last;
    assign eob_tag       = out_q.user[23];
    assign drop_cnt      = drop_cnt_q;
endmodule

// File: tb/tb_bin_mask_framer_2048mmax.sv
// Self-checking bench for bin_mask_framer_2048mmax: directed frames with random data,
// compared against a frame-level reference model (enabled bins in order, tlast on the last one).
module tb_bin_mask_framer_2048mmax;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        sync_reset;
    logic [11:0] fft_size;
    logic        mask_wr_en;
    logic [10:0] mask_wr_addr;
    logic        mask_wr_data;
    logic [15:0] drop_cnt;
    logic        eob_tag;

    bin_mask_framer_2048mmax_if s_if ();
    bin_mask_framer_2048mmax_if m_if ();

    bin_mask_framer_2048mmax dut (
        .clk          (clk),
        .sync_reset   (sync_reset),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .fft_size     (fft_size),
        .mask_wr_en   (mask_wr_en),
        .mask_wr_addr (mask_wr_addr),
        .mask_wr_data (mask_wr_data),
        .drop_cnt     (drop_cnt),
        .eob_tag      (eob_tag)
    );

    typedef struct packed {
        logic [23:0] u;
        logic [31:0] d;
        logic        l;
        logic        eob;
    } beat_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    beat_t exp_q[$];
    beat_t got_q[$];
    beat_t cur_frame[$];
    bit    model_mask [64];
    int    drop_exp = 0;
    int    stall_left = 0;
    int    rdy_mode = 1;
    bit    saw_bp = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a frame's output is its enabled bins in arrival order, tlast on the final one.
    task automatic model_accept(input logic [31:0] d, input logic [23:0] u, input logic last);
        beat_t t;
        bit    en;
        en = (int'(u[10:0]) < 64) && model_mask[u[5:0]] && (int'(u[10:0]) < int'(fft_size));
        if (en) cur_frame.push_back('{u: u, d: d, l: 1'b0, eob: u[23]});
        else    drop_exp = (drop_exp + 1) % 65536;
        if (last) begin
            if (cur_frame.size() > 0) begin
                t = cur_frame.pop_back();
                t.l = 1'b1;
                cur_frame.push_back(t);
            end
            while (cur_frame.size() > 0) exp_q.push_back(cur_frame.pop_front());
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [10:0] bin, input logic last);
        logic [31:0] d;
        logic [23:0] u;
        bit          taken;
        int          guard;
        d = $urandom;
        u = 24'($urandom);
        u[10:0] = bin;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tuser  = u;
        s_if.tlast  = last;
        taken = 1'b0;
        guard = 0;
        while (!taken && guard < 5000) begin
            @(negedge clk);
            taken = s_if.tready;
            if (taken) model_accept(d, u, last);
            if (mask_wr_en) model_mask[mask_wr_addr[5:0]] = mask_wr_data;
            @(posedge clk);
            #1;
            mask_wr_en = 1'b0;
            guard++;
        end
        check("input accepted within budget", 64'(taken), 64'd1);
        s_if.tvalid = 1'b0;
    endtask

    task automatic send_frame(input int nbins, input int gap_pct, input int wr_bin,
                              input logic wr_val, input bit with_last);
        for (int b = 0; b < nbins; b++) begin
            if (b == wr_bin) begin
                mask_wr_en   = 1'b1;
                mask_wr_addr = 11'(b);
                mask_wr_data = wr_val;
            end
            send_beat(11'(b), with_last && (b == nbins - 1));
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) idle(1);
        end
    endtask

    task automatic write_mask(input int addr, input logic val);
        mask_wr_en   = 1'b1;
        mask_wr_addr = 11'(addr);
        mask_wr_data = val;
        @(posedge clk);
        #1;
        mask_wr_en = 1'b0;
        model_mask[addr] = val;
    endtask

    task automatic fill_mask(input int mode);
        for (int i = 0; i < 64; i++) begin
            case (mode)
                0:       write_mask(i, 1'b0);
                1:       write_mask(i, 1'b1);
                default: write_mask(i, 1'($urandom_range(1)));
            endcase
        end
    endtask

    task automatic drain(input string tag, output int n_got);
        beat_t e;
        beat_t g;
        int    guard;
        guard = 0;
        while (guard < 3000 && (got_q.size() < exp_q.size() || guard < 12)) begin
            @(posedge clk);
            #1;
            guard++;
        end
        n_got = got_q.size();
        check({tag, " output count"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check({tag, " tdata"}, 64'(g.d), 64'(e.d));
            check({tag, " tuser"}, 64'(g.u), 64'(e.u));
            check({tag, " tlast"}, 64'(g.l), 64'(e.l));
            check({tag, " eob_tag"}, 64'(g.eob), 64'(e.eob));
        end
        exp_q.delete();
        got_q.delete();
        check({tag, " drop_cnt"}, 64'(drop_cnt), 64'(drop_exp));
    endtask

    task automatic do_reset(input int cycles);
        sync_reset  = 1'b1;
        s_if.tvalid = 1'b0;
        idle(cycles);
        sync_reset = 1'b0;
        exp_q.delete();
        got_q.delete();
        cur_frame.delete();
        drop_exp = 0;
    endtask

    always @(posedge clk) begin
        #1;
        if (stall_left > 0) begin
            stall_left--;
            m_if.tready = 1'b0;
        end else begin
            case (rdy_mode)
                0:       m_if.tready = 1'b0;
                1:       m_if.tready = 1'b1;
                default: m_if.tready = ($urandom_range(99) < 70);
            endcase
        end
    end

    // Output monitor: collects handshaken beats and checks the stall-hold rule.
    bit    stalled = 1'b0;
    beat_t stall_beat;
    always @(negedge clk) begin
        if (sync_reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("valid held under backpressure", 64'(m_if.tvalid), 64'd1);
                check("beat held under backpressure",
                      64'({m_if.tuser, m_if.tdata, m_if.tlast}),
                      64'({stall_beat.u, stall_beat.d, stall_beat.l}));
            end
            if (m_if.tvalid && m_if.tready)
                got_q.push_back('{u: m_if.tuser, d: m_if.tdata, l: m_if.tlast, eob: eob_tag});
            stalled    = m_if.tvalid && !m_if.tready;
            stall_beat = '{u: m_if.tuser, d: m_if.tdata, l: m_if.tlast, eob: eob_tag};
            if (!s_if.tready) saw_bp = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        sync_reset   = 1'b1;
        fft_size     = 12'd64;
        mask_wr_en   = 1'b0;
        mask_wr_addr = '0;
        mask_wr_data = 1'b0;
        s_if.tvalid  = 1'b0;
        s_if.tdata   = '0;
        s_if.tuser   = '0;
        s_if.tlast   = 1'b0;
        m_if.tready  = 1'b1;
        idle(3);
        sync_reset = 1'b0;
        idle(1);

        check("reset m_axis_tvalid", 64'(m_if.tvalid), 64'd0);
        check("reset m_axis_tlast", 64'(m_if.tlast), 64'd0);
        check("reset m_axis_tdata", 64'(m_if.tdata), 64'd0);
        check("reset m_axis_tuser", 64'(m_if.tuser), 64'd0);
        check("reset drop_cnt", 64'(drop_cnt), 64'd0);
        check("reset s_axis_tready", 64'(s_if.tready), 64'd1);

        // All bins enabled, one full-rate 64-bin frame.
        fill_mask(1);
        send_frame(64, 0, -1, 1'b0, 1'b1);
        drain("all_enabled", n);
        check("all_enabled outputs", 64'(n), 64'd64);
        check("all_enabled drop_cnt", 64'(drop_cnt), 64'd0);

        // Sparse mask: bins 3, 10, 40 only.
        fill_mask(0);
        write_mask(3, 1'b1);
        write_mask(10, 1'b1);
        write_mask(40, 1'b1);
        send_frame(64, 0, -1, 1'b0, 1'b1);
        drain("sparse", n);
        check("sparse outputs", 64'(n), 64'd3);
        check("sparse drop_cnt", 64'(drop_cnt), 64'd61);

        // Only the tlast bin enabled, two frames back to back.
        fill_mask(0);
        write_mask(63, 1'b1);
        send_frame(64, 0, -1, 1'b0, 1'b1);
        send_frame(64, 0, -1, 1'b0, 1'b1);
        drain("last_only", n);
        check("last_only outputs", 64'(n), 64'd2);

        // Empty frame, then a frame with only bin 0 enabled.
        fill_mask(0);
        send_frame(64, 0, -1, 1'b0, 1'b1);
        drain("empty", n);
        check("empty outputs", 64'(n), 64'd0);
        write_mask(0, 1'b1);
        send_frame(64, 0, -1, 1'b0, 1'b1);
        drain("bin0_only", n);
        check("bin0_only outputs", 64'(n), 64'd1);

        // fft_size boundary: bins 60..63 dropped even though enabled.
        fill_mask(1);
        fft_size = 12'd60;
        send_frame(64, 0, -1, 1'b0, 1'b1);
        drain("fft_size60", n);
        check("fft_size60 outputs", 64'(n), 64'd60);
        fft_size = 12'd64;

        // Downstream stalled for 200 cycles under full-rate input.
        saw_bp     = 1'b0;
        stall_left = 200;
        for (int f = 0; f < 4; f++) send_frame(64, 0, -1, 1'b0, 1'b1);
        drain("stall", n);
        check("stall outputs", 64'(n), 64'd256);
        check("stall s_axis_tready fell", 64'(saw_bp), 64'd1);

        // Random masks, sizes, gaps and downstream readiness.
        rdy_mode = 2;
        for (int f = 0; f < 5; f++) begin
            fill_mask(2);
            fft_size = 12'($urandom_range(64, 40));
            send_frame(64, 30, -1, 1'b0, 1'b1);
            send_frame(64, 0, -1, 1'b0, 1'b1);
            drain("random", n);
        end
        rdy_mode = 1;
        fft_size = 12'd64;

        // Mask bin 5 cleared in the cycle bin 5 is taken: old bit still applies to that sample.
        fill_mask(1);
        send_frame(64, 0, 5, 1'b0, 1'b1);
        drain("wr_same_cycle", n);
        check("wr_same_cycle outputs", 64'(n), 64'd64);
        send_frame(64, 0, -1, 1'b0, 1'b1);
        drain("wr_after", n);
        check("wr_after outputs", 64'(n), 64'd63);

        // Reset in the middle of a frame; mask contents survive.
        send_frame(20, 0, -1, 1'b0, 1'b0);
        do_reset(2);
        check("midreset m_axis_tvalid", 64'(m_if.tvalid), 64'd0);
        check("midreset drop_cnt", 64'(drop_cnt), 64'd0);
        check("midreset m_axis_tdata", 64'(m_if.tdata), 64'd0);
        send_frame(64, 0, -1, 1'b0, 1'b1);
        drain("post_reset", n);
        check("post_reset outputs", 64'(n), 64'd63);
        check("post_reset drop_cnt", 64'(drop_cnt), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
